switch_src_arbiter: RTL and testbench

SWITCH_SRC_ARBITER -- requirements
Module: switch_src_arbiter

---
 rtl/switch_src_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_switch_src_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_src_arbiter.sv
// ---------------------------------------------------------------------------
// switch_src_arbiter
//
// Purpose
//   Shares one switch source port between NUM_REQ requesters. In IDLE a
//   round-robin scan starting at rr_ptr picks the first requester with
//   req_valid high. The winner owns the port in XFER until it sends a beat
//   with req_last, or until its MAX_BURST-th beat is accepted. Either event
//   returns the block to IDLE and moves rr_ptr to the owner plus one. Every
//   grant is followed by at least one IDLE cycle.
//
// Handshake (valid/ready)
//   A beat moves when valid and ready are both high at a rising clk edge.
//   This holds on both sides: requester i to arbiter (req_valid[i] and
//   req_ready[i]), and arbiter to switch (src_valid and src_ready). In XFER
//   the owner is wired straight through: src_valid follows
//   req_valid[grant_id] and req_ready[grant_id] follows src_ready. Both
//   accepts therefore happen on the same edge. A valid never waits for a
//   ready, and ready alone never moves a beat.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req_valid/last   per-requester beat valid / final beat of packet
//   req_addr/data    per-requester fields, requester i at [i*W +: W]
//   req_ready        per-requester accept
//   src_valid/addr/data, src_ready   switch source port
//   grant_id, busy   current owner (meaningful only while busy) / grant held
//   dbg_state        FSM state (0 = IDLE, 1 = XFER)
//   dbg_rr_ptr       round-robin scan start for the next arbitration
//   dbg_beat_cnt     beats accepted in the current (or last) grant
// ---------------------------------------------------------------------------
module switch_src_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        src_valid,
  output logic [ADDR_W-1:0]           src_addr,
  output logic [DATA_W-1:0]           src_data,
  input  logic                        src_ready,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output logic                        dbg_state,
  output logic [GW-1:0]               dbg_rr_ptr,
  output logic [CW-1:0]               dbg_beat_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     w_grant_nxt;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     w_rr_ptr_nxt;
  logic [CW-1:0]     r_beat;
  logic [CW-1:0]     w_beat_nxt;
  logic [GW-1:0]     w_pick;
  logic              w_any_valid;
  logic              w_accept;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;

  // Returns the first index at or above ptr with v set, wrapping from
  // NUM_REQ-1 back to 0. The result is only used when some bit of v is set.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && v[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_any_valid = |req_valid;
  assign w_pick      = rr_pick(req_valid, r_rr_ptr);

  // Select the owner's fields. A compare per requester avoids a variable
  // part-select on the wide address/data buses.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_addr  = '0;
    w_gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_gnt_valid = req_valid[i];
        w_gnt_last  = req_last[i];
        w_gnt_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_beat_nxt   = r_beat;
    w_accept     = 1'b0;
    busy         = 1'b0;
    src_valid    = 1'b0;
    src_addr     = '0;
    src_data     = '0;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_XFER;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      ST_XFER: begin
        busy               = 1'b1;
        src_valid          = w_gnt_valid;
        src_addr           = w_gnt_addr;
        src_data           = w_gnt_data;
        req_ready[r_grant] = src_ready;
        w_accept           = w_gnt_valid && src_ready;
        // A stall (src_ready low) or a gap (owner valid low) leaves every
        // register untouched. The grant is held and is not re-arbitrated.
        if (w_accept) begin
          w_beat_nxt = r_beat + 1'b1;
          // r_beat counts beats before this one, so MAX_BURST-1 marks the
          // MAX_BURST-th beat.
          if (w_gnt_last || (r_beat == CW'(MAX_BURST - 1))) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register. Reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_beat   <= w_beat_nxt;
    end
  end

  assign grant_id     = r_grant;
  assign dbg_state    = r_state;
  assign dbg_rr_ptr   = r_rr_ptr;
  assign dbg_beat_cnt = r_beat;

endmodule

// File: tb/tb_switch_src_arbiter.sv
module tb_switch_src_arbiter;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int GW = 2;
  localparam int CW = 3;
  localparam int OW = 1 + 1 + GW + 1 + AW + DW + N + GW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            src_valid, src_ready, busy, dbg_state;
  logic [AW-1:0]   src_addr;
  logic [DW-1:0]   src_data;
  logic [GW-1:0]   grant_id, dbg_rr_ptr;
  logic [CW-1:0]   dbg_beat_cnt;

  switch_src_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
    .src_ready(src_ready), .grant_id(grant_id), .busy(busy),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_beat_cnt(dbg_beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard: expected grant order ----------------
  logic [GW-1:0] exp_q[$];
  logic          prev_busy;

  // ---------------- reference model (packet/owner level) ----------------
  int m_owner;  // -1 = no grant held
  int m_rr;
  int m_beats;

  function automatic logic [OW-1:0] model_out();
    logic          b, sv;
    logic [GW-1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  r;
    b = (m_owner >= 0);
    sv = 1'b0; g = '0; a = '0; d = '0; r = '0;
    if (b) begin
      sv = req_valid[m_owner];
      g  = GW'(m_owner);
      a  = req_addr[m_owner*AW +: AW];
      d  = req_data[m_owner*DW +: DW];
      r[m_owner] = src_ready;
    end
    return {b, b, g, sv, a, d, r, GW'(m_rr), CW'(m_beats)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {busy, dbg_state, (busy ? grant_id : GW'(0)), src_valid, src_addr, src_data,
            req_ready, dbg_rr_ptr, dbg_beat_cnt};
  endfunction

  function automatic void model_step();
    int i;
    if (reset) begin
      m_owner = -1; m_rr = 0; m_beats = 0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (req_valid[i]) begin
          m_owner = i; m_beats = 0;
          break;
        end
      end
    end else if (req_valid[m_owner] && src_ready) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MB) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endfunction

  // ---------------- driver ----------------
  int       rem[N];   // packets still to send
  int       len[N];   // beats per packet
  int       pos[N];   // current beat within packet
  int       drop[N];  // cycles of forced valid-low
  logic [7:0] salt[N];
  int       rdy_mode; // 0 low, 1 high, 2 random
  int       rdy_pct;

  task automatic clear_drivers();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; len[i] = 1; pos[i] = 0; drop[i] = 0; salt[i] = 8'($urandom);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rem[i] > 0) && (drop[i] == 0);
      req_last[i]  = (pos[i] == len[i] - 1);
      req_addr[i*AW +: AW] = {8'(i), salt[i], 32'(pos[i])};
      req_data[i*DW +: DW] = {salt[i], 8'(i), 16'(pos[i]) ^ 16'hA5C3};
    end
    src_ready = (rdy_mode == 2) ? ($urandom_range(99) < rdy_pct) : (rdy_mode == 1);
  endtask

  task automatic advance();
    int   o;
    logic hit;
    o   = m_owner;
    hit = !reset && (o >= 0) && req_valid[o] && src_ready;
    model_step();
    if (hit) begin
      if (req_last[o]) begin
        rem[o]--; pos[o] = 0; salt[o] = 8'($urandom);
      end else begin
        pos[o]++;
      end
    end
    for (int i = 0; i < N; i++) if (drop[i] > 0) drop[i]--;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_drivers();
    rdy_mode = 1;
    reset = 1'b1;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_owner = -1; m_rr = 0; m_beats = 0;
    prev_busy = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_drivers();
    for (int i = 0; i < N; i++) rem[i] = 1;
    rdy_mode = 1;
    reset = 1'b1;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({busy, dbg_state, src_valid, req_ready} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%h exp=0", {busy, dbg_state, src_valid, req_ready});
    end
    checks++;
    if ({src_addr, src_data} !== '0) begin
      errors++; $display("FAIL reset_bus got=%h exp=0", {src_addr, src_data});
    end
    checks++;
    if ({grant_id, dbg_rr_ptr, dbg_beat_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {grant_id, dbg_rr_ptr, dbg_beat_cnt});
    end
    reset = 1'b0;
  endtask

  task automatic test_two_req();
    logic [GW-1:0] g;
    do_reset();
    rem[1] = 1; rem[3] = 1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    for (int c = 0; c < 6; c++) begin
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL two_req cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (busy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL two_req_order extra grant got=%0d", grant_id); end
        else begin
          g = exp_q.pop_front();
          if (grant_id !== g) begin errors++; $display("FAIL two_req_order got=%0d exp=%0d", grant_id, g); end
        end
      end
      prev_busy = busy;
      advance();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL two_req_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [GW-1:0] g;
    do_reset();
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 12; c++) begin
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL round_robin cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (busy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rr_order extra grant got=%0d", grant_id); end
        else begin
          g = exp_q.pop_front();
          if (grant_id !== g) begin errors++; $display("FAIL rr_order got=%0d exp=%0d", grant_id, g); end
        end
      end
      prev_busy = busy;
      advance();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_max_burst();
    logic [GW-1:0] g;
    do_reset();
    rem[2] = 1; len[2] = 6;
    exp_q = '{2'd2, 2'd3, 2'd0, 2'd2};
    for (int c = 0; c < 14; c++) begin
      if (c == 1) begin rem[0] = 1; rem[3] = 1; end
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL max_burst cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (c == 5) begin
        checks++;
        if (busy !== 1'b0 || dbg_rr_ptr !== 2'd3) begin
          errors++; $display("FAIL max_burst_release got busy=%0b rr=%0d exp busy=0 rr=3", busy, dbg_rr_ptr);
        end
      end
      if (busy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL burst_order extra grant got=%0d", grant_id); end
        else begin
          g = exp_q.pop_front();
          if (grant_id !== g) begin errors++; $display("FAIL burst_order got=%0d exp=%0d", grant_id, g); end
        end
      end
      prev_busy = busy;
      advance();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL burst_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    rem[1] = 1; len[1] = 6;
    for (int c = 0; c < 14; c++) begin
      rdy_mode = (c >= 2 && c <= 4) ? 0 : 1;
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL stall cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (src_data !== req_data[DW +: DW] || src_addr !== req_addr[AW +: AW] ||
            dbg_beat_cnt !== 3'd1 || req_ready !== 4'b0000 || src_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got data=%h cnt=%0d rdy=%b exp data=%h cnt=1 rdy=0000",
                   c, src_data, dbg_beat_cnt, req_ready, req_data[DW +: DW]);
        end
      end
      advance();
    end
  endtask

  task automatic test_valid_drop();
    logic [GW-1:0] g;
    do_reset();
    rem[1] = 1; len[1] = 4;
    exp_q = '{2'd1, 2'd0};
    for (int c = 0; c < 12; c++) begin
      if (c == 1) rem[0] = 1;
      if (c == 2) drop[1] = 2;
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL valid_drop cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || src_valid !== 1'b0) begin
          errors++; $display("FAIL drop_hold cyc=%0d got busy=%0b gnt=%0d sv=%0b exp 1/1/0",
                             c, busy, grant_id, src_valid);
        end
      end
      if (busy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL drop_order extra grant got=%0d", grant_id); end
        else begin
          g = exp_q.pop_front();
          if (grant_id !== g) begin errors++; $display("FAIL drop_order got=%0d exp=%0d", grant_id, g); end
        end
      end
      prev_busy = busy;
      advance();
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [GW-1:0] g;
    do_reset();
    rem[2] = 1; len[2] = 4;
    exp_q = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int c = 0; c < 13; c++) begin
      reset = (c == 2);
      if (c == 3) begin
        for (int i = 0; i < N; i++) begin rem[i] = 1; len[i] = 1; pos[i] = 0; end
      end
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      if (c == 3) begin
        checks++;
        if ({busy, src_valid, src_addr, src_data, req_ready} !== '0) begin
          errors++; $display("FAIL reset_mid_zero got=%h exp=0", {busy, src_valid, src_addr, src_data, req_ready});
        end
      end
      if (busy && !prev_busy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_order extra grant got=%0d", grant_id); end
        else begin
          g = exp_q.pop_front();
          if (grant_id !== g) begin errors++; $display("FAIL rmid_order got=%0d exp=%0d", grant_id, g); end
        end
      end
      prev_busy = busy;
      advance();
    end
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    rdy_mode = 2; rdy_pct = 70;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(199) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(7) == 0) begin
          rem[i] = $urandom_range(2, 1); len[i] = $urandom_range(7, 1); pos[i] = 0;
        end
        if (drop[i] == 0 && $urandom_range(15) == 0) drop[i] = $urandom_range(3, 1);
      end
      drive();
      @(negedge clk);
      checks++;
      if (dut_out() !== model_out()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_out(), model_out());
      end
      advance();
    end
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    src_ready = 1'b0;
    req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
    rdy_mode = 1; rdy_pct = 100;
    prev_busy = 1'b0;
    m_owner = -1; m_rr = 0; m_beats = 0;
    test_reset();
    test_two_req();
    test_round_robin();
    test_max_burst();
    test_stall();
    test_valid_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
